// File: rtl/axis_uart_tx.sv
// -----------------------------------------------------------------------------
// axis_uart_tx
//   Serialises an 8-bit AXI-Stream byte stream onto an asynchronous UART line.
//   Frame: start bit (0), D0..D7 LSB first, optional parity bit, 1 or 2 stop
//   bits (1). Every bit holds the line for CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
//   clock cycles. The block backpressures the upstream slicer: a new byte is
//   only accepted while idle or in the very last cycle of the last stop bit,
//   which allows zero-gap back-to-back frames.
//
// Ports
//   i_CLK         in   1  system clock, rising edge
//   i_RST         in   1  asynchronous reset, active-high
//   S_AXIS_DATA   in   8  byte to transmit
//   S_AXIS_VALID  in   1  S_AXIS_DATA is valid
//   S_AXIS_READY  out  1  byte accepted on a rising edge with VALID high
//   o_TX          out  1  UART serial line, idle high
//   o_BUSY        out  1  frame in progress
//
// All outputs come straight from registers; nothing is combinational from
// an input.
// -----------------------------------------------------------------------------
module axis_uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [7:0] S_AXIS_DATA,
    input  logic       S_AXIS_VALID,
    output logic       S_AXIS_READY,
    output logic       o_TX,
    output logic       o_BUSY
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // One cycle before the end of a bit: used to pre-register READY so that
    // it is high exactly in the final cycle of the last stop bit.
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    // Elaboration-time parameter checks.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("axis_uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("axis_uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;       // cycles within the current bit
    logic [2:0]       bit_idx_reg;   // data bit index 0..7
    logic             stop_idx_reg;  // stop bit index 0..STOP_BITS-1
    logic [7:0]       shift_reg;     // remaining data bits, LSB goes out next
    logic             parity_reg;
    logic             tx_reg;
    logic             ready_reg;
    logic             busy_reg;

    logic handshake;
    logic bit_end;
    logic last_stop;

    assign handshake = S_AXIS_VALID & ready_reg;
    assign bit_end   = (cnt_reg == CNT_LAST);
    assign last_stop = (stop_idx_reg == STOP_LAST);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (handshake) begin
                        state_reg  <= START;
                        shift_reg  <= S_AXIS_DATA;
                        parity_reg <= (^S_AXIS_DATA) ^ ODD_BIT;
                        tx_reg     <= 1'b0;
                        busy_reg   <= 1'b1;
                        ready_reg  <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state_reg   <= DATA;
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_reg <= PARITY;
                                tx_reg    <= parity_reg;
                            end else begin
                                state_reg    <= STOP;
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state_reg    <= STOP;
                        tx_reg       <= 1'b1;
                        cnt_reg      <= '0;
                        stop_idx_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (last_stop) begin
                            // READY is high in this cycle, so a waiting byte
                            // chains straight into the next start bit.
                            if (handshake) begin
                                state_reg  <= START;
                                shift_reg  <= S_AXIS_DATA;
                                parity_reg <= (^S_AXIS_DATA) ^ ODD_BIT;
                                tx_reg     <= 1'b0;
                                busy_reg   <= 1'b1;
                                ready_reg  <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                                tx_reg    <= 1'b1;
                                busy_reg  <= 1'b0;
                                ready_reg <= 1'b1;
                            end
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_stop && cnt_reg == CNT_PRE) begin
                            ready_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign S_AXIS_READY = ready_reg;
    assign o_TX         = tx_reg;
    assign o_BUSY       = busy_reg;

endmodule
